divider_taint_track: RTL

Sequential restoring divider with cell-level taint tracking; the inverse counterpart of the team's multiplier_taint_track.
- Produces one quotient bit per cycle: WIDTH-bit unsigned quotient and remainder.
- Every data and control signal carries a shadow _t signal that propagates taint conservatively.
- Sits beside the multiplier in the arithmetic unit, sharing its start/done handshake style, so information-flow checkers see both blocks alike.

---
 rtl/divider_taint_track_pkg.sv | 22 ++
 rtl/divider_datapath_taint_track.sv | 76 +++++++
 rtl/divider_taint_track.sv | 91 +++++++++
 3 files changed

// File: rtl/divider_taint_track_pkg.sv
// Shared definitions for the taint-tracking restoring divider: state encoding,
// counter sizing and the taint OR-reduce helper.
package divider_taint_track_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Widest taint vector the OR-reduce helper accepts; callers zero-extend.
  localparam int TAINT_MAX_W = 1024;

  function automatic int counter_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Any tainted bit taints every bit derived from the whole vector; callers
  // replicate the result across the destination width.
  function automatic logic taint_any(input logic [TAINT_MAX_W-1:0] t);
    return |t;
  endfunction

endpackage

// File: rtl/divider_datapath_taint_track.sv
// Remainder/quotient/divisor registers of the restoring divider together with
// the compare/subtract step and its conservative taint propagation.
module divider_datapath_taint_track
  import divider_taint_track_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] remainder_t
);

  logic [WIDTH-1:0] dvd, dvd_t, dsr, dsr_t;
  logic [WIDTH:0]   shifted, shifted_t;
  logic [WIDTH-1:0] diff;
  logic             sub_sel, sub_sel_t, in_any_t;

  assign shifted   = {remainder, dvd[WIDTH-1]};
  assign shifted_t = {remainder_t, dvd_t[WIDTH-1]};
  assign sub_sel   = shifted >= {1'b0, dsr};
  assign sub_sel_t = taint_any(TAINT_MAX_W'(shifted_t)) | taint_any(TAINT_MAX_W'(dsr_t));
  assign in_any_t  = taint_any(TAINT_MAX_W'(divisor_t));
  // The restoring invariant keeps shifted < 2*divisor, so the low bits suffice.
  assign diff      = shifted[WIDTH-1:0] - dsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd         <= '0;
      dvd_t       <= '0;
      dsr         <= '0;
      dsr_t       <= '0;
      quotient    <= '0;
      quotient_t  <= '0;
      remainder   <= '0;
      remainder_t <= '0;
    end else if (load) begin
      dvd   <= dividend;
      dvd_t <= dividend_t;
      dsr   <= divisor;
      dsr_t <= divisor_t;
      if (divisor == '0) begin
        quotient    <= '1;
        quotient_t  <= {WIDTH{in_any_t}};
        remainder   <= dividend;
        remainder_t <= dividend_t | {WIDTH{in_any_t}};
      end else begin
        quotient    <= '0;
        quotient_t  <= '0;
        remainder   <= '0;
        remainder_t <= '0;
      end
    end else if (step) begin
      dvd        <= {dvd[WIDTH-2:0], 1'b0};
      dvd_t      <= {dvd_t[WIDTH-2:0], 1'b0};
      quotient   <= {quotient[WIDTH-2:0], sub_sel};
      quotient_t <= {quotient_t[WIDTH-2:0], sub_sel_t};
      remainder  <= sub_sel ? diff : shifted[WIDTH-1:0];
      if (sub_sel_t)
        remainder_t <= '1;
      else if (sub_sel && |(shifted_t | {1'b0, dsr_t}))
        remainder_t <= '1;
      else
        remainder_t <= shifted_t[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/divider_taint_track.sv
// Sequential restoring divider with cell-level taint tracking; FSM, cycle
// counter and control taint live here, arithmetic lives in the datapath.
module divider_taint_track
  import divider_taint_track_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] remainder_t,
  output logic             quotientDone,
  output logic             quotientDone_t,
  output logic             divByZero,
  output logic             divByZero_t
);

  localparam int CNT_W = counter_width(WIDTH);

  logic [1:0]       state;
  logic             state_t;
  logic [CNT_W-1:0] count;
  logic             accept, step, divisor_zero, divisor_any_t;

  assign accept        = (state == IDLE) && start;
  assign step          = (state == RUN);
  assign divisor_zero  = (divisor == '0);
  assign divisor_any_t = taint_any(TAINT_MAX_W'(divisor_t));

  assign quotientDone_t = state_t & ((state == DONE) || (state == IDLE));

  // The counter only reaches DONE as zero on the divide-by-zero shortcut,
  // so it doubles as the record of which path was taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      state_t      <= 1'b0;
      count        <= '0;
      quotientDone <= 1'b0;
      divByZero    <= 1'b0;
      divByZero_t  <= 1'b0;
    end else begin
      quotientDone <= (state == DONE);
      case (state)
        IDLE: begin
          state_t <= start_t | (start & divisor_any_t);
          if (start) begin
            count       <= '0;
            divByZero   <= 1'b0;
            divByZero_t <= divisor_any_t;
            state       <= divisor_zero ? DONE : RUN;
          end
        end
        RUN: begin
          count <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1))
            state <= DONE;
        end
        DONE: begin
          divByZero <= (count == '0);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  divider_datapath_taint_track #(.WIDTH(WIDTH)) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .step        (step),
    .dividend    (dividend),
    .dividend_t  (dividend_t),
    .divisor     (divisor),
    .divisor_t   (divisor_t),
    .quotient    (quotient),
    .quotient_t  (quotient_t),
    .remainder   (remainder),
    .remainder_t (remainder_t)
  );

endmodule
